player_motion_ctrl: RTL
=======================

Name: player_motion_ctrl

Overview:
- Upstream of the video controller: produces player_hStartPos/player_vStartPos/player_objWidth/player_objHeight that the display compare stage consumes.
- Samples the 4 movement buttons once per video frame, timed by the controller's VS output.
- Moves the player sprite with a speed ramp and clamps it to the 640x480 visible area.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
OBJ_W, 16, player width (driven on player_objWidth)
OBJ_H, 16, player height (driven on player_objHeight)
H_INIT, 312, reset horizontal position
V_INIT, 232, reset vertical position
STEP_MIN, 1, initial pixels per frame
STEP_MAX, 4, maximum pixels per frame
RAMP_FRAMES, 8, held frames per speed increment

Ports:
clk  in  1  system clock (100 MHz)
rst  in  1  asynchronous, active-low reset
btns  in  4  [0]=up [1]=down [2]=left [3]=right, active-high, asynchronous to clk
vs  in  1  VS from video controller, active-low pulse, asynchronous to clk
player_hStartPos  out  32  sprite left edge, 0..H_ACTIVE-OBJ_W
player_vStartPos  out  32  sprite top edge, 0..V_ACTIVE-OBJ_H
player_objWidth  out  32  constant OBJ_W
player_objHeight  out  32  constant OBJ_H
frame_tick  out  1  one-clk pulse per detected frame
speed  out  4  current step in pixels/frame
moving  out  1  high while state is not IDLE

Behaviour:
- Reset (rst=0, async):
  - hPos=H_INIT, vPos=V_INIT, speed=STEP_MIN.
  - ramp_cnt=0, dir_q=0, state=IDLE, frame_tick=0, moving=0.
  - Synchronizer flops reset to 1 for vs and to 0 for btns.
- Synchronization: btns and vs each pass through 2 flops (s1, s2). A third vs flop s3 drives edge detect.
- Frame tick: frame_tick <= s3 & ~s2 (registered falling-edge detect).
  - frame_tick is high for exactly 1 clk per VS falling edge.
  - It rises on the 3rd clk edge after vs is first sampled low.
- Updates occur only on the clk edge where frame_tick=1. Outputs change 1 clk after frame_tick rises.
- Direction vector, computed at tick:
  - dh = right - left; dv = down - up.
  - Opposite buttons together cancel that axis (d=0). Diagonal movement is allowed.
  - dir = {dh,dv}. dir==0 means nothing held.
- State machine (evaluated at tick):
  - IDLE:
    - dir==0: stay, speed=STEP_MIN.
    - dir!=0: go to ACCEL, move this tick by STEP_MIN, ramp_cnt=1, dir_q=dir.
  - ACCEL:
    - dir==0: go to IDLE, speed=STEP_MIN, ramp_cnt=0, no move.
    - dir!=dir_q: stay in ACCEL, speed=STEP_MIN, ramp_cnt=1, dir_q=dir, move by STEP_MIN.
    - dir==dir_q:
      - Move by the current speed.
      - When ramp_cnt==RAMP_FRAMES-1: ramp_cnt=0, speed+=1. If the new speed==STEP_MAX, go to CRUISE.
      - Otherwise ramp_cnt+=1.
  - CRUISE:
    - dir==dir_q: move by STEP_MAX.
    - dir==0: go to IDLE, reset as above.
    - dir changed: go to ACCEL, reset as above.
- Move arithmetic:
  - Speed is applied to each nonzero axis independently, unsigned 32-bit.
  - Left/up: if pos < speed then pos=0, else pos-=speed. Compare before subtracting; no underflow.
  - Right/down: if pos+speed > MAX (MAX = H_ACTIVE-OBJ_W or V_ACTIVE-OBJ_H) then pos=MAX, else pos+=speed.
  - Clamping does not alter state or speed.
- Button changes between ticks are ignored; only the synchronized value at the tick is used.
- rst assertion mid-move returns everything to reset values immediately.
- player_objWidth and player_objHeight are constants, independent of reset.

Optional Feature:
- Macro: PLAYER_WRAP_EN.
- Defined:
  - An overflowing right/down move sets pos=0.
  - An underflowing left/up move (pos < speed) sets pos=MAX.
  - This is edge-to-edge wrap, not modulo.
- Undefined: clamp behaviour as above.
- State machine and speed ramp are identical in both builds.

Test Plan:
- Reset: hold rst=0, toggle vs and btns -> hPos=312, vPos=232, speed=1, moving=0, frame_tick=0. Release rst; no motion without a vs fall.
- Ramp: hold right, 30 vs falls -> per-frame steps 1x8, 2x8, 3x8, 4x6. hPos=312+8+16+24+24=384. State CRUISE after frame 24. frame_tick pulses exactly 30, each 1 clk wide.
- Clamp: hPos=620, speed=4, right held -> 624 then stays 624. With left from hPos=2, speed=4 -> 0, never wraps. vPos clamps at 464.
- Cancel/change: left+right+down held -> only vPos moves. Switching down->up mid-ramp -> speed=1, ramp restarts. Releasing all -> IDLE, speed=1.
- Async reset mid-move: assert rst between ticks in CRUISE -> outputs reset without waiting for a clk edge. First tick after release moves by 1.
- PLAYER_WRAP_EN: hPos=622, speed=4, right -> hPos=0. vPos=2, speed=4, up -> vPos=464.

Source files
------------

// File: rtl/player_motion_ctrl.sv
// Player sprite motion: samples buttons once per VS frame, applies a speed ramp and keeps the
// sprite in the visible area. Define PLAYER_WRAP_EN for edge-to-edge wrap instead of clamping.
module player_motion_ctrl #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned OBJ_W       = 16,
  parameter int unsigned OBJ_H       = 16,
  parameter int unsigned H_INIT      = 312,
  parameter int unsigned V_INIT      = 232,
  parameter int unsigned STEP_MIN    = 1,
  parameter int unsigned STEP_MAX    = 4,
  parameter int unsigned RAMP_FRAMES = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btns,
  input  logic        vs,
  output logic [31:0] player_hStartPos,
  output logic [31:0] player_vStartPos,
  output logic [31:0] player_objWidth,
  output logic [31:0] player_objHeight,
  output logic        frame_tick,
  output logic [3:0]  speed,
  output logic        moving
);

  localparam logic [31:0] H_MAX   = 32'(H_ACTIVE - OBJ_W);
  localparam logic [31:0] V_MAX   = 32'(V_ACTIVE - OBJ_H);
  localparam int unsigned RAMP_W  = (RAMP_FRAMES > 1) ? $clog2(RAMP_FRAMES) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_FRAMES - 1);
  localparam logic [3:0]  SMIN    = 4'(STEP_MIN);
  localparam logic [3:0]  SMAX    = 4'(STEP_MAX);

  typedef enum logic [1:0] {
    IDLE,
    ACCEL,
    CRUISE
  } state_t;

  state_t            state;
  logic              vsS1, vsS2, vsS3;
  logic [3:0]        btnS1, btnS2;
  logic              frameTick;
  logic [31:0]       hPos, vPos;
  logic [3:0]        speedQ;
  logic [RAMP_W-1:0] rampCnt;
  logic [3:0]        dirQ;
  logic              movingQ;

  logic [1:0]        dh, dv;
  logic [3:0]        dir;
  logic [3:0]        stepUse;

  // Axis deltas as 2-bit two's complement: 01 = +1, 11 = -1, 00 = none or cancelled.
  always_comb begin
    dh  = {1'b0, btnS2[3]} - {1'b0, btnS2[2]};
    dv  = {1'b0, btnS2[1]} - {1'b0, btnS2[0]};
    dir = {dh, dv};
    if (state == IDLE || dir != dirQ)
      stepUse = SMIN;
    else if (state == CRUISE)
      stepUse = SMAX;
    else
      stepUse = speedQ;
  end

  // A zero delta leaves the position untouched, so every tick can apply this unconditionally.
  function automatic logic [31:0] moveAxis(input logic [31:0] pos, input logic [1:0] d,
                                           input logic [3:0] step, input logic [31:0] maxPos);
    logic [32:0] sum;
    sum      = {1'b0, pos} + 33'(step);
    moveAxis = pos;
    if (d == 2'b11) begin
      if (pos < 32'(step))
`ifdef PLAYER_WRAP_EN
        moveAxis = maxPos;
`else
        moveAxis = '0;
`endif
      else
        moveAxis = pos - 32'(step);
    end else if (d == 2'b01) begin
      if (sum > {1'b0, maxPos})
`ifdef PLAYER_WRAP_EN
        moveAxis = '0;
`else
        moveAxis = maxPos;
`endif
      else
        moveAxis = sum[31:0];
    end
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vsS1 <= 1'b1;
      vsS2 <= 1'b1;
      vsS3 <= 1'b1;
      btnS1 <= '0;
      btnS2 <= '0;
      frameTick <= 1'b0;
    end else begin
      vsS1 <= vs;
      vsS2 <= vsS1;
      vsS3 <= vsS2;
      btnS1 <= btns;
      btnS2 <= btnS1;
      frameTick <= vsS3 & ~vsS2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      hPos    <= 32'(H_INIT);
      vPos    <= 32'(V_INIT);
      speedQ  <= SMIN;
      rampCnt <= '0;
      dirQ    <= '0;
      movingQ <= 1'b0;
    end else if (frameTick) begin
      hPos <= moveAxis(hPos, dh, stepUse, H_MAX);
      vPos <= moveAxis(vPos, dv, stepUse, V_MAX);
      if (dir == '0) begin
        state   <= IDLE;
        speedQ  <= SMIN;
        rampCnt <= '0;
        movingQ <= 1'b0;
      end else if (state == IDLE || dir != dirQ) begin
        state   <= ACCEL;
        speedQ  <= SMIN;
        rampCnt <= RAMP_W'(1);
        dirQ    <= dir;
        movingQ <= 1'b1;
      end else if (state == ACCEL) begin
        if (rampCnt == RAMP_LAST) begin
          rampCnt <= '0;
          speedQ  <= speedQ + 4'd1;
          if (speedQ + 4'd1 == SMAX)
            state <= CRUISE;
        end else begin
          rampCnt <= rampCnt + RAMP_W'(1);
        end
      end
    end
  end

  assign player_hStartPos = hPos;
  assign player_vStartPos = vPos;
  assign player_objWidth  = 32'(OBJ_W);
  assign player_objHeight = 32'(OBJ_H);
  assign frame_tick       = frameTick;
  assign speed            = speedQ;
  assign moving           = movingQ;

endmodule
